alu_pipe: RTL
=============

Name: alu_pipe

Overview:
Parametrised, registered successor to the team's 8-bit combinational ALU.
- Width is generic.
- Input and output use valid/ready handshakes.
- Results and a four-bit flag set are registered.
- Adds arithmetic shift, unsigned compare and an iterative multi-cycle multiply.
- Sits between the operand/decode stage and writeback.
- Exactly one operation is in flight at a time.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of two).
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept an operation this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  4  opcode
out_valid  out  1  result/flags valid
out_ready  in  1  downstream accepts result
result  out  WIDTH  registered result
zero  out  1  result == 0
negative  out  1  result[WIDTH-1]
carry  out  1  carry/borrow/multiply-high flag
overflow  out  1  signed overflow flag

Behaviour:
- Reset: asynchronous, active-low (rst_n=0). Clears result, all flags, out_valid and the multiply counter; state=IDLE. in_ready=1 after release. Reset mid-multiply aborts it; no output is produced.
- Handshake rules:
  - Transfer occurs when valid && ready on a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready); combinational, no dependence on in_valid.
  - result and flags hold stable while out_valid && !out_ready.
  - out_valid falls after the out handshake unless a new result is loaded on the same edge.
- States:
  - IDLE: accepts an operation. Non-MUL ops stay in IDLE; MUL goes to MUL.
  - MUL: shift-add, one multiplier bit per cycle, in_ready=0. After WIDTH cycles, loads the output register and returns to IDLE.
- Latency:
  - Non-MUL: out_valid=1 the cycle after acceptance.
  - MUL: out_valid=1 exactly WIDTH cycles after acceptance.
  - Back-to-back non-MUL ops give full throughput: one per cycle while out_ready=1.
- Opcodes and flags (carry and overflow are 0 unless stated):
  - 0 ADD: result = a+b. carry = bit WIDTH of the sum. overflow = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
  - 1 SUB: result = a-b. carry = borrow (a<b unsigned). overflow = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SHL, 6 SHR (logical), 7 SRA (arithmetic): shift amount = b[SHW-1:0].
  - 8 SLT: result = 1 if $signed(a) < $signed(b), else 0.
  - 9 SLTU: result = 1 if a < b unsigned, else 0.
  - 10 MUL: unsigned product; result = low WIDTH bits; carry = 1 if the high WIDTH bits are nonzero.
  - 11-15: result=0, zero=1, other flags 0. Completes with 1-cycle latency.
- zero and negative are always derived from the registered result.
- Operands are captured on acceptance. Input changes after acceptance have no effect.

Test Plan:
- WIDTH=8, ADD a=8'h7F, b=8'h01 -> next cycle out_valid=1, result=8'h80, overflow=1, negative=1, carry=0, zero=0.
- SUB a=8'h00, b=8'h01 -> result=8'hFF, carry=1, overflow=0. SUB a=8'h80, b=8'h01 -> result=8'h7F, overflow=1.
- SRA a=8'h90, b=8'h03 -> result=8'hF2. SHR same operands -> 8'h12. SLT a=8'hFF, b=8'h01 -> 1. SLTU same operands -> 0.
- MUL a=8'h10, b=8'h10:
  - in_ready=0 for 8 cycles.
  - out_valid on the 8th cycle after acceptance.
  - result=8'h00, carry=1, zero=1.
- Hold out_ready=0 after an ADD result while driving in_valid:
  - in_ready stays 0 and result stays stable.
  - Release out_ready: the next op is accepted on the same edge, and its result appears the following cycle.
- Assert rst_n=0 at cycle 3 of a MUL -> out_valid=0 and result=0 immediately. After release: in_ready=1, and a fresh ADD 3+4 returns 7.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU with flags and iterative multiply
// One operation in flight; MUL runs a WIDTH-cycle shift-add loop, everything else completes next cycle.
module alu_pipe #(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam int MSB = WIDTH - 1;
   localparam logic [3:0] OP_MUL = 4'd10;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_overflow;
   logic               r_out_valid;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic [SHW-1:0]     r_cnt;

   logic               w_accept;
   logic               w_out_fire;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [SHW-1:0]     w_shamt;
   logic [WIDTH-1:0]   w_sra;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic [2*WIDTH-1:0] w_mul_next;
   logic               w_mul_last;

   assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_out_fire = r_out_valid && out_ready;

   assign w_sum   = {1'b0, a} + {1'b0, b};
   assign w_diff  = {1'b0, a} - {1'b0, b};
   assign w_shamt = b[SHW-1:0];
   assign w_sra   = $signed(a) >>> w_shamt;

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (op)
         4'd0: begin
            w_res = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
         end
         4'd1: begin
            // the extra top bit of the widened difference is the borrow
            w_res = w_diff[MSB:0];
            w_c   = w_diff[WIDTH];
            w_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
         end
         4'd2:    w_res = a & b;
         4'd3:    w_res = a | b;
         4'd4:    w_res = a ^ b;
         4'd5:    w_res = a << w_shamt;
         4'd6:    w_res = a >> w_shamt;
         4'd7:    w_res = w_sra;
         4'd8:    w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd9:    w_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: w_res = '0;
      endcase
   end

   assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
         r_mcand     <= '0;
         r_acc       <= '0;
         r_mplier    <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept && op == OP_MUL) begin
                  r_mcand     <= {{WIDTH{1'b0}}, a};
                  r_mplier    <= b;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_out_valid <= 1'b0;
                  r_state     <= S_MUL;
               end else if (w_accept) begin
                  r_result    <= w_res;
                  r_carry     <= w_c;
                  r_overflow  <= w_v;
                  r_out_valid <= 1'b1;
               end else if (w_out_fire) begin
                  r_out_valid <= 1'b0;
               end
            end
            S_MUL: begin
               r_acc    <= w_mul_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + SHW'(1);
               if (w_mul_last) begin
                  r_result    <= w_mul_next[MSB:0];
                  r_carry     <= |w_mul_next[2*WIDTH-1:WIDTH];
                  r_overflow  <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_IDLE;
               end else if (w_out_fire) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign carry     = r_carry;
   assign overflow  = r_overflow;
   assign zero      = (r_result == '0);
   assign negative  = r_result[MSB];

endmodule
